// File: rtl/count_sched.sv
// count_sched: serializes clear / up / down / autocount operations on one
// host-visible event counter. Requests latch into sticky pending flags, a
// two-state FSM grants one at a time (clr > up > down > auto) and applies it.
// Optional build macro COUNT_SCHED_SATURATE_EN: up/auto saturate at all-ones,
// down saturates at zero, and the wrap pulses are tied low.
module count_sched #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DIV_W      = 24,
  parameter logic [DIV_W-1:0] DIV_RELOAD = 24'h100000
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             clr_req,
  input  logic             up_req,
  input  logic             down_req,
  input  logic             auto_en,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap_hi,
  output logic             wrap_lo,
  output logic             eq_zero,
  output logic [7:0]       drop_cnt
);

  typedef enum logic {S_IDLE, S_EXEC} state_t;
  // Auto requests execute as OP_UP once granted.
  typedef enum logic [1:0] {OP_CLR, OP_UP, OP_DN} op_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  // Flag bit order doubles as grant priority: bit 0 wins.
  logic [3:0]       req;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       grant;
  logic [3:0]       drop;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             grant_en;
  logic [7:0]       drop_q, drop_d;
  logic             eq_zero_q;

  state_t           state_q;
  op_t              op_q;
  logic [WIDTH-1:0] count_q;
  logic             busy_q, done_q, wrap_hi_q, wrap_lo_q;

  // Returns {wrap_hi, wrap_lo, next_count} for an operation on count c.
  function automatic logic [WIDTH+1:0] apply_op(input op_t op, input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] ones;
    ones = '1;
    case (op)
      OP_CLR: apply_op = {2'b00, {WIDTH{1'b0}}};
`ifdef COUNT_SCHED_SATURATE_EN
      OP_UP:  apply_op = {2'b00, (c == ones) ? c : c + CNT_ONE};
      OP_DN:  apply_op = {2'b00, (c == '0) ? c : c - CNT_ONE};
`else
      OP_UP:  apply_op = {(c == ones), 1'b0, c + CNT_ONE};
      OP_DN:  apply_op = {1'b0, (c == '0), c - CNT_ONE};
`endif
      default: apply_op = {2'b00, c};
    endcase
  endfunction

  // Adds the number of requests lost this cycle, sticking at 8'hFF.
  function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [3:0] d);
    logic [2:0] n;
    logic [8:0] sum;
    n   = 3'(d[0]) + 3'(d[1]) + 3'(d[2]) + 3'(d[3]);
    sum = {1'b0, acc} + {6'd0, n};
    sat_add = sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Divider tick, request gathering, priority grant and drop detection.
  always_comb begin
    tick     = (div_q == '0);
    div_d    = tick ? DIV_RELOAD : div_q - DIV_ONE;
    req      = {tick & auto_en, down_req, up_req, clr_req};
    grant_en = (state_q == S_IDLE) && !hold && (pend_q != 4'b0000);
    grant    = 4'b0000;
    if (grant_en) begin
      if (pend_q[0])      grant = 4'b0001;
      else if (pend_q[1]) grant = 4'b0010;
      else if (pend_q[2]) grant = 4'b0100;
      else                grant = 4'b1000;
    end
    // A request landing on its own grant cycle re-arms the flag, not a drop.
    drop   = req & pend_q & ~grant;
    pend_d = (pend_q & ~grant) | req;
    drop_d = sat_add(drop_q, drop);
  end

  // Pending flags, free-running divider, drop counter and zero flag.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q    <= 4'b0000;
      div_q     <= DIV_RELOAD;
      drop_q    <= 8'd0;
      eq_zero_q <= 1'b1;
    end else begin
      pend_q    <= pend_d;
      div_q     <= div_d;
      drop_q    <= drop_d;
      eq_zero_q <= (count_q == '0);
    end
  end

  // Scheduler FSM: IDLE grants one flag, EXEC applies it with registered pulses.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_CLR;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrap_hi_q <= 1'b0;
      wrap_lo_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      wrap_hi_q <= 1'b0;
      wrap_lo_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_en) begin
            op_q    <= grant[0] ? OP_CLR : (grant[2] ? OP_DN : OP_UP);
            busy_q  <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          {wrap_hi_q, wrap_lo_q, count_q} <= apply_op(op_q, count_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrap_hi  = wrap_hi_q;
  assign wrap_lo  = wrap_lo_q;
  assign eq_zero  = eq_zero_q;
  assign drop_cnt = drop_q;

endmodule

// File: doc/count_sched.md
# count_sched

Command scheduler that owns one host-visible event counter and serializes every operation on it. Sources are host trigger pulses (clear, up, down) from the `okTriggerIn` side and an internal autocount tick. It latches each request, grants one at a time under fixed priority, and applies it to the count. Wrap, zero and drop status are reported for `okTriggerOut` and `okWireOut` endpoints.

## Interface
Parameters:
- `WIDTH`, 8: count width.
- `DIV_W`, 24: autocount divider width.
- `DIV_RELOAD`, 24'h100000: divider reload value; the tick period is `DIV_RELOAD`+1 cycles.

Ports:
- `sys_clk` in 1: the only clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `clr_req` in 1: single-cycle clear request.
- `up_req` in 1: single-cycle increment request.
- `down_req` in 1: single-cycle decrement request.
- `auto_en` in 1: level; allows divider ticks to post auto-increment requests.
- `hold` in 1: level; blocks new grants while high.
- `count` out `WIDTH`: current count value.
- `busy` out 1: high while the FSM is in EXEC.
- `done` out 1: one-cycle pulse when an operation is applied.
- `wrap_hi` out 1: one-cycle pulse on all-ones to 0 by increment.
- `wrap_lo` out 1: one-cycle pulse on 0 to all-ones by decrement.
- `eq_zero` out 1: registered `count`==0.
- `drop_cnt` out 8: number of lost requests, saturates at 8'hFF.

Reset values: `count`=0, `busy`=0, `done`=0, `wrap_hi`=0, `wrap_lo`=0, `eq_zero`=1, `drop_cnt`=0. All pending flags clear, FSM in IDLE, divider at `DIV_RELOAD`.

## Operation
Pending flags:
- There are four sticky flags: `p_clr`, `p_up`, `p_dn`, `p_auto`.
- A request pulse sets its flag on the same edge it is sampled.
- A request arriving while its flag is already set and not being granted this cycle is dropped, and `drop_cnt` increments (saturating).
- A request arriving in the same cycle its flag is granted re-sets the flag. It is not dropped.
- The divider decrements every cycle regardless of `hold` or `auto_en`.
- At 0 the divider reloads `DIV_RELOAD`. If `auto_en`=1 this is an auto request, handled by the same drop rule.

FSM states:
- IDLE: if `hold`=0 and any flag is set, grant the highest-priority flag (priority clr > up > down > auto), clear that flag, register the op, and go to EXEC. Otherwise stay in IDLE.
- EXEC: apply the op to `count`, pulse `done` (plus `wrap_hi`/`wrap_lo` if applicable), and return to IDLE.
- One operation completes at most every 2 cycles.

Op rules:
- clr: `count`=0.
- up and auto: `count`+1, modulo 2^`WIDTH`.
- down: `count`-1, modulo 2^`WIDTH`.
- Granting clr does not flush other pending flags.
- Lower-priority flags may starve under continuous higher-priority traffic. This is accepted behaviour.
- `eq_zero` is recomputed from `count` each cycle, so it lags `count` by 1.

## Timing
- Request sampled at edge k: flag set at k, grant at k+1, and `count`/`done` updated at k+2 if the FSM was idle and `hold`=0.
- `busy` is high for exactly the EXEC cycle.
- `hold` is sampled only in IDLE. An op already in EXEC always completes.
- `reset_n` asserted mid-EXEC aborts the op immediately; all outputs go to their reset values with no `done`.
- After `reset_n` deasserts, the first grant is possible on the second rising edge.

## Configuration
- `COUNT_SCHED_SATURATE_EN` defined:
  - up/auto at all-ones leaves `count` at all-ones.
  - down at 0 leaves `count` at 0.
  - `done` still pulses.
  - `wrap_hi` and `wrap_lo` are tied 0.
- `COUNT_SCHED_SATURATE_EN` undefined: modulo arithmetic and wrap pulses as described in Operation.

## Test plan
- Reset, then `up_req` pulse at edge k: `count`=1 and `done`=1 at edge k+2; `eq_zero`=0 at k+3.
- `clr_req`, `up_req` and `down_req` pulsed in the same cycle, starting from `count`=5: ops apply in order 0, 1, 0 on edges k+2, k+4, k+6; `drop_cnt`=0.
- Two `up_req` pulses at edges k and k+1 with `hold`=1: second pulse dropped, `drop_cnt`=1. Release `hold`: `count` increments once.
- `count`=8'hFF, then `up_req`: `count`=8'h00 with `wrap_hi` pulse. From 0, `down_req`: `count`=8'hFF with `wrap_lo` pulse. With the macro defined: `count` holds at 8'hFF and at 0, no wrap pulses.
- `DIV_RELOAD`=3, `auto_en`=1 for 40 cycles with no other traffic: count advances by 10 (one tick per 4 cycles).
- `reset_n` low during EXEC of an up op at `count`=7: `count`=0 immediately, no `done`, all flags cleared.
